// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the EXE-stage hazard controller:
// FSM state encoding and ALU operand forwarding-select codes.
package exe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Single-operand forwarding selector: picks MEM over WB over register file,
// never forwarding from x0.
module fwd_unit
  import exe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic              reg_write_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              reg_write_wb_i,
  output logic [1:0]        sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = reg_write_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i);
  assign wb_hit  = reg_write_wb_i  && (rd_wb_i  != '0) && (rd_wb_i  == rs_i);

  always_comb begin
    sel_o = FWD_REG;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_REG;
    end
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage pipeline controller: operand forwarding, single-cycle load-use
// stall, multi-cycle squash on a taken branch, and stall/flush event counters.
module exe_hazard_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_AW       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1_ID_IN,
  input  logic [REG_AW-1:0] RS2_ID_IN,
  input  logic              USES_RS2_ID_IN,
  input  logic [REG_AW-1:0] RS1_EX_IN,
  input  logic [REG_AW-1:0] RS2_EX_IN,
  input  logic [REG_AW-1:0] RD_EX_IN,
  input  logic              MEM_READ_EX_IN,
  input  logic              BRANCH_EX_IN,
  input  logic              ZERO_EX_IN,
  input  logic [REG_AW-1:0] RD_MEM_IN,
  input  logic              REG_WRITE_MEM_IN,
  input  logic [REG_AW-1:0] RD_WB_IN,
  input  logic              REG_WRITE_WB_IN,
  output logic              PC_WE_OUT,
  output logic              IFID_WE_OUT,
  output logic              IDEX_BUBBLE_OUT,
  output logic              FLUSH_OUT,
  output logic [1:0]        FWD_A_SEL_OUT,
  output logic [1:0]        FWD_B_SEL_OUT,
  output logic [31:0]       STALL_COUNT_OUT,
  output logic [31:0]       FLUSH_COUNT_OUT
);

  // Remaining FLUSH-state cycles loaded on detection; the detection cycle itself is not counted.
  localparam int         FLUSH_INIT_INT = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [1:0] FLUSH_INIT     = 2'(FLUSH_INIT_INT);
  localparam bit         FLUSH_MULTI    = (FLUSH_CYCLES > 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic        taken;
  logic        load_use;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  assign taken    = BRANCH_EX_IN && ZERO_EX_IN;
  assign load_use = MEM_READ_EX_IN && (RD_EX_IN != '0) &&
                    ((RD_EX_IN == RS1_ID_IN) || (USES_RS2_ID_IN && (RD_EX_IN == RS2_ID_IN)));

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i            (RS1_EX_IN),
    .rd_mem_i        (RD_MEM_IN),
    .reg_write_mem_i (REG_WRITE_MEM_IN),
    .rd_wb_i         (RD_WB_IN),
    .reg_write_wb_i  (REG_WRITE_WB_IN),
    .sel_o           (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i            (RS2_EX_IN),
    .rd_mem_i        (RD_MEM_IN),
    .reg_write_mem_i (REG_WRITE_MEM_IN),
    .rd_wb_i         (RD_WB_IN),
    .reg_write_wb_i  (REG_WRITE_WB_IN),
    .sel_o           (fwd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN, STALL: begin
        // load_use is only acted on from RUN so a stall never lasts more than one cycle
        if (taken) begin
          flush_cnt_d = flush_cnt_q + 32'd1;
          state_d     = FLUSH_MULTI ? FLUSH : RUN;
          cnt_d       = FLUSH_INIT;
        end else if (load_use && (state_q == RUN)) begin
          stall_cnt_d = stall_cnt_q + 32'd1;
          state_d     = STALL;
        end else begin
          state_d     = RUN;
        end
      end
      FLUSH: begin
        if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    PC_WE_OUT       = 1'b1;
    IFID_WE_OUT     = 1'b1;
    IDEX_BUBBLE_OUT = 1'b0;
    FLUSH_OUT       = 1'b0;
    if (rst) begin
      PC_WE_OUT       = 1'b0;
      IFID_WE_OUT     = 1'b0;
      IDEX_BUBBLE_OUT = 1'b1;
      FLUSH_OUT       = 1'b1;
    end else begin
      case (state_q)
        RUN, STALL: begin
          if (taken) begin
            IDEX_BUBBLE_OUT = 1'b1;
            FLUSH_OUT       = 1'b1;
          end else if (load_use && (state_q == RUN)) begin
            PC_WE_OUT       = 1'b0;
            IFID_WE_OUT     = 1'b0;
            IDEX_BUBBLE_OUT = 1'b1;
          end else begin
            IDEX_BUBBLE_OUT = 1'b0;
          end
        end
        FLUSH: begin
          IDEX_BUBBLE_OUT = 1'b1;
          FLUSH_OUT       = 1'b1;
        end
        default: begin
          IDEX_BUBBLE_OUT = 1'b0;
        end
      endcase
    end
  end

  assign FWD_A_SEL_OUT   = rst ? FWD_REG : fwd_a;
  assign FWD_B_SEL_OUT   = rst ? FWD_REG : fwd_b;
  assign STALL_COUNT_OUT = stall_cnt_q;
  assign FLUSH_COUNT_OUT = flush_cnt_q;

endmodule
